// File: rtl/controller_write_enable_if.sv
// Write-enable handshake between the RX datapath (done) and the storage write port (enable).
interface controller_write_enable_if;
  logic done;
  logic enable;

  modport master (output done, input enable);
  modport slave  (input done, output enable);
endinterface

// File: rtl/controller_write_enable.sv
// Turns the RX "byte assembled" level into one registered write-enable pulse of PULSE_CYCLES cycles.
//   state    | meaning
//   IDLE     | armed, waiting for done high
//   PULSE    | enable high, counter running down to zero
//   WAIT_LOW | pulse finished, done still high; wait for it to drop before re-arming
module controller_write_enable #(
  parameter int PULSE_CYCLES = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  controller_write_enable_if.slave   wr
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE    = 2'd1,
    WAIT_LOW = 2'd2
  } state_e;

  localparam logic [7:0] LOAD = 8'(PULSE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       enable_q, enable_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr.done) begin
          state_d  = PULSE;
          cnt_d    = LOAD;
          enable_d = 1'b1;
        end
      end
      PULSE: begin
        // done is ignored while the pulse runs, so glitches can neither retrigger nor stretch it
        if (cnt_q != 8'd0) begin
          cnt_d    = cnt_q - 8'd1;
          enable_d = 1'b1;
        end else begin
          state_d = wr.done ? WAIT_LOW : IDLE;
        end
      end
      WAIT_LOW: begin
        if (!wr.done) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      enable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enable_q <= enable_d;
    end
  end

  assign wr.enable = enable_q;

endmodule

// File: tb/tb_controller_write_enable.sv
// Randomized + directed bench for controller_write_enable at PULSE_CYCLES = 1 and 3, scoreboard-checked.
module tb_controller_write_enable;

  logic clk;
  logic reset;
  logic done;

  controller_write_enable_if if1 ();
  controller_write_enable_if if3 ();

  assign if1.done = done;
  assign if3.done = done;

  controller_write_enable #(.PULSE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .wr(if1.slave));
  controller_write_enable #(.PULSE_CYCLES(3)) dut3 (.clk(clk), .reset(reset), .wr(if3.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit    exp1;
    bit    exp3;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model: pulse "remaining" count, last output, and whether done has
  // been seen low since the last pulse (armed). Index 0 -> width 1, index 1 -> width 3.
  int width[2] = '{1, 3};
  int left[2];
  bit en[2];
  bit armed[2];

  task automatic model_step(input int i, input bit r, input bit d, output bit e);
    if (r) begin
      left[i] = 0; en[i] = 1'b0; armed[i] = 1'b1;
    end else if (en[i]) begin
      if (left[i] > 0) begin
        left[i]--; en[i] = 1'b1;
      end else begin
        en[i] = 1'b0; armed[i] = !d;
      end
    end else if (!armed[i]) begin
      if (!d) armed[i] = 1'b1;
    end else if (d) begin
      en[i] = 1'b1; left[i] = width[i] - 1; armed[i] = 1'b0;
    end
    e = en[i];
  endtask

  task automatic drive(input bit r, input bit d, input int n, input string tag);
    exp_t x;
    bit e1, e3;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      reset = r;
      done  = d;
      model_step(0, r, d, e1);
      model_step(1, r, d, e3);
      x.exp1 = e1; x.exp3 = e3; x.tag = tag;
      exp_q.push_back(x);
    end
  endtask

  // Monitor: enable is valid every cycle; sample 1 time unit after the edge
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        vectors++;
        if (if1.enable !== x.exp1) begin
          miscompares++;
          $display("FAIL %s w1: enable=%b expected=%b at t=%0t", x.tag, if1.enable, x.exp1, $time);
        end
        vectors++;
        if (if3.enable !== x.exp3) begin
          miscompares++;
          $display("FAIL %s w3: enable=%b expected=%b at t=%0t", x.tag, if3.enable, x.exp3, $time);
        end
      end
    end
  end

  initial begin
    int lvl, len;
    reset = 1'b1;
    done  = 1'b0;
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; en[i] = 1'b0; armed[i] = 1'b1;
    end

    drive(1, 0, 1, "reset");
    drive(0, 0, 2, "post_reset");
    drive(0, 1, 10, "long_done");
    drive(0, 0, 3, "long_done_low");
    drive(0, 1, 2, "retrig_a");
    drive(0, 0, 2, "retrig_gap");
    drive(0, 1, 2, "retrig_b");
    drive(0, 0, 4, "retrig_low");
    drive(0, 1, 1, "single_a");
    drive(0, 0, 2, "single_gap");
    drive(0, 1, 1, "single_b");
    drive(0, 0, 4, "single_low");
    drive(0, 1, 6, "width_hold");
    drive(0, 0, 4, "width_low");
    drive(0, 1, 1, "width_drop");
    drive(0, 0, 5, "width_drop_low");
    drive(0, 1, 1, "toggle_h1");
    drive(0, 0, 1, "toggle_l");
    drive(0, 1, 1, "toggle_h2");
    drive(0, 0, 5, "toggle_end");
    drive(0, 1, 5, "gap1_a");
    drive(0, 0, 1, "gap1_low");
    drive(0, 1, 5, "gap1_b");
    drive(0, 0, 3, "gap1_end");
    drive(0, 1, 2, "rst_mid_pre");
    drive(1, 1, 1, "rst_mid");
    drive(0, 1, 5, "rst_mid_after");
    drive(0, 0, 3, "rst_mid_end");

    for (int n = 0; n < 150; n++) begin
      lvl = int'($urandom_range(1, 0));
      len = int'($urandom_range(8, 1));
      if ($urandom_range(99, 0) < 4) drive(1, lvl[0], 1, "rand_rst");
      else drive(0, lvl[0], len, "rand");
    end
    drive(0, 0, 5, "final_low");

    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
